// File: rtl/mips_defs.sv
// Shared MIPS decode constants, forwarding encodings and the IF/ID payload type.
package mips_defs;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] SPECIAL = 6'h00;
  localparam logic [5:0] J       = 6'h02;
  localparam logic [5:0] JAL     = 6'h03;
  localparam logic [5:0] BEQ     = 6'h04;
  localparam logic [5:0] BNE     = 6'h05;
  localparam logic [5:0] ANDI    = 6'h0c;
  localparam logic [5:0] ORI     = 6'h0d;
  localparam logic [5:0] XORI    = 6'h0e;
  localparam logic [5:0] LUI     = 6'h0f;

  // SPECIAL funct codes (instr[5:0])
  localparam logic [5:0] JR      = 6'h08;
  localparam logic [5:0] JALR    = 6'h09;

  // Forwarding select encodings; 2'd3 falls back to the GRF value
  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_3000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } ifId_t;

  // Pick the operand source for one forwarding mux.
  function automatic logic [XLEN-1:0] fwdMux(input logic [1:0] sel,
                                             input logic [XLEN-1:0] grfVal,
                                             input logic [XLEN-1:0] eVal,
                                             input logic [XLEN-1:0] mVal);
    case (sel)
      FWD_E:   fwdMux = eVal;
      FWD_M:   fwdMux = mVal;
      default: fwdMux = grfVal;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_grf.sv
// grf: 32x32 general register file, async active-low clear, one write port,
// two combinational read ports with same-cycle write-back bypass. $0 reads 0.
// Ports: clk, reset, rsAddr/rtAddr (read), regWrite/regAddr/regData (write),
//        rsData/rtData (read data).
module grf
  import mips_defs::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rsAddr,
  input  logic [REG_AW-1:0] rtAddr,
  input  logic              regWrite,
  input  logic [REG_AW-1:0] regAddr,
  input  logic [XLEN-1:0]   regData,
  output logic [XLEN-1:0]   rsData,
  output logic [XLEN-1:0]   rtData
);

  logic [XLEN-1:0] regFile [32];
  logic            wrEn;

  assign wrEn = regWrite && (regAddr != '0);

  // Storage; entry 0 is never written so it stays zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regFile[i] <= '0;
    end else if (wrEn) begin
      regFile[regAddr] <= regData;
    end
  end

  // Read with bypass so a value being written back this cycle is visible now.
  always_comb begin
    rsData = regFile[rsAddr];
    rtData = regFile[rtAddr];
    if (wrEn && (regAddr == rsAddr)) rsData = regData;
    if (wrEn && (regAddr == rtAddr)) rtData = regData;
    if (rsAddr == '0) rsData = '0;
    if (rtAddr == '0) rtData = '0;
  end

endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS decode stage. Holds the IF/ID register, the GRF, rs/rt
// forwarding muxes and branch/jump resolution (one delay slot, no flush).
// Ports: clk, reset (async active-low), stall; pc/instr from fetch;
//        write-back port (regWrite_W/regAddr_W/regData_W); forwarding data and
//        selects; redirect (pc_Id, ifPcBranch_Id) back to fetch; pc, instr,
//        forwarded rs/rt and extended immediate to EX.
module id_stage
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC  = mips_defs::RESET_PC,
  parameter logic [31:0] NOP_INSTR = mips_defs::NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [XLEN-1:0]   pc_IfToId,
  input  logic [XLEN-1:0]   instr_IfToId,
  input  logic              regWrite_W,
  input  logic [REG_AW-1:0] regAddr_W,
  input  logic [XLEN-1:0]   regData_W,
  input  logic [XLEN-1:0]   fwdData_E,
  input  logic [XLEN-1:0]   fwdData_M,
  input  logic [1:0]        fwdSelRs_Id,
  input  logic [1:0]        fwdSelRt_Id,
  output logic [XLEN-1:0]   pc_Id,
  output logic              ifPcBranch_Id,
  output logic [XLEN-1:0]   pc_IdToEx,
  output logic [XLEN-1:0]   instr_IdToEx,
  output logic [XLEN-1:0]   rsData_IdToEx,
  output logic [XLEN-1:0]   rtData_IdToEx,
  output logic [XLEN-1:0]   extImm_IdToEx
);

  ifId_t           ifIdQ;
  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [15:0]     imm16;
  logic [XLEN-1:0] rsGrf;
  logic [XLEN-1:0] rtGrf;
  logic [XLEN-1:0] rsFwd;
  logic [XLEN-1:0] rtFwd;
  logic [XLEN-1:0] pcPlus4;
  logic [XLEN-1:0] branchOff;

  // IF/ID pipeline register; reset discards the held instruction immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifIdQ <= '{pc: RESET_PC, instr: NOP_INSTR};
    end else if (!stall) begin
      ifIdQ <= '{pc: pc_IfToId, instr: instr_IfToId};
    end
  end

  assign opcode = ifIdQ.instr[31:26];
  assign funct  = ifIdQ.instr[5:0];
  assign imm16  = ifIdQ.instr[15:0];

  grf uGrf (
    .clk      (clk),
    .reset    (reset),
    .rsAddr   (ifIdQ.instr[25:21]),
    .rtAddr   (ifIdQ.instr[20:16]),
    .regWrite (regWrite_W),
    .regAddr  (regAddr_W),
    .regData  (regData_W),
    .rsData   (rsGrf),
    .rtData   (rtGrf)
  );

  // Forwarded operands feed both the comparator and EX.
  assign rsFwd = fwdMux(fwdSelRs_Id, rsGrf, fwdData_E, fwdData_M);
  assign rtFwd = fwdMux(fwdSelRt_Id, rtGrf, fwdData_E, fwdData_M);

  assign pcPlus4   = ifIdQ.pc + 32'd4;
  assign branchOff = {{14{imm16[15]}}, imm16, 2'b00};

  // Branch/jump resolution; evaluated every cycle regardless of stall.
  always_comb begin
    ifPcBranch_Id = 1'b0;
    pc_Id         = pcPlus4;
    case (opcode)
      BEQ: if (rsFwd == rtFwd) begin
        ifPcBranch_Id = 1'b1;
        pc_Id         = pcPlus4 + branchOff;
      end
      BNE: if (rsFwd != rtFwd) begin
        ifPcBranch_Id = 1'b1;
        pc_Id         = pcPlus4 + branchOff;
      end
      J, JAL: begin
        ifPcBranch_Id = 1'b1;
        pc_Id         = {pcPlus4[31:28], ifIdQ.instr[25:0], 2'b00};
      end
      SPECIAL: if ((funct == JR) || (funct == JALR)) begin
        ifPcBranch_Id = 1'b1;
        pc_Id         = rsFwd;
      end
      default: ;
    endcase
  end

  // Logical immediates zero-extend; everything else sign-extends.
  always_comb begin
    extImm_IdToEx = {{16{imm16[15]}}, imm16};
    if ((opcode == ORI) || (opcode == ANDI) || (opcode == XORI) || (opcode == LUI))
      extImm_IdToEx = {16'h0000, imm16};
  end

  assign pc_IdToEx     = ifIdQ.pc;
  assign instr_IdToEx  = ifIdQ.instr;
  assign rsData_IdToEx = rsFwd;
  assign rtData_IdToEx = rtFwd;

endmodule
